// File: rtl/uart_rx_deframer_if.sv
// Receive-side bundle between the UART deframer and its LCR/LSR/FIFO logic.
// The slave side is the deframer; the master side drives line control, serial input and pop.
interface uart_rx_deframer_if;
    logic [7:0] lcr;
    logic       srx_pad_i;
    logic       enable;
    logic       rx_reset;
    logic       lsr_mask;
    logic       rx_pop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pe;
    logic       rx_fe;
    logic       rx_bi;
    logic       rx_overrun;
    logic [2:0] rstate;

    modport master (
        output lcr, srx_pad_i, enable, rx_reset, lsr_mask, rx_pop,
        input  rx_data, rx_valid, rx_pe, rx_fe, rx_bi, rx_overrun, rstate
    );

    modport slave (
        input  lcr, srx_pad_i, enable, rx_reset, lsr_mask, rx_pop,
        output rx_data, rx_valid, rx_pe, rx_fe, rx_bi, rx_overrun, rstate
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises srx_pad_i, validates start bit, shifts 5-8 data bits, parity, stop.
// Capture at mid stop bit (8+16*(N+P+1) enables after first low); one-entry hold, overflow sets sticky rx_overrun.
module uart_rx_deframer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           wb_rst_i,
    uart_rx_deframer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [2:0]             r_bits;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic                   r_pe_nxt;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_pe;
    logic                   r_fe;
    logic                   r_bi;
    logic                   r_ovr;

    logic                   w_rx;
    logic [2:0]             w_pos;
    logic                   w_exp_par;
    logic                   w_bi_nxt;

    assign w_rx     = r_sync[SYNC_STAGES-1];
    assign w_pos    = 3'd4 + {1'b0, bus.lcr[1:0]} - r_bits;
    assign w_bi_nxt = (r_shift == 8'd0) & (~bus.lcr[3] | ~r_par) & ~w_rx;

    // {EP,SP}: odd, stick-1, even, stick-0
    always_comb begin
        w_exp_par = 1'b0;
        case ({bus.lcr[4], bus.lcr[5]})
            2'b00:   w_exp_par = ~^r_shift;
            2'b01:   w_exp_par = 1'b1;
            2'b10:   w_exp_par = ^r_shift;
            default: w_exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_sync   <= '1;
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_bits   <= 3'd0;
            r_shift  <= 8'd0;
            r_par    <= 1'b0;
            r_pe_nxt <= 1'b0;
            r_data   <= 8'd0;
            r_valid  <= 1'b0;
            r_pe     <= 1'b0;
            r_fe     <= 1'b0;
            r_bi     <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.srx_pad_i};
            if (bus.lsr_mask)
                r_ovr <= 1'b0;
            if (bus.rx_reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
                r_valid <= 1'b0;
                r_pe    <= 1'b0;
                r_fe    <= 1'b0;
                r_bi    <= 1'b0;
            end else begin
                if (bus.rx_pop)
                    r_valid <= 1'b0;
                if (bus.enable) begin
                    case (r_state)
                        ST_IDLE: begin
                            if (!w_rx) begin
                                r_cnt   <= 4'd7;
                                r_state <= ST_START;
                            end
                        end
                        ST_START: begin
                            if (r_cnt != 4'd0) begin
                                r_cnt <= r_cnt - 4'd1;
                            end else if (w_rx) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_cnt    <= 4'd15;
                                r_bits   <= 3'd4 + {1'b0, bus.lcr[1:0]};
                                r_shift  <= 8'd0;
                                r_par    <= 1'b0;
                                r_pe_nxt <= 1'b0;
                                r_state  <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            if (r_cnt != 4'd0) begin
                                r_cnt <= r_cnt - 4'd1;
                            end else begin
                                r_shift[w_pos] <= w_rx;
                                r_cnt          <= 4'd15;
                                if (r_bits == 3'd0)
                                    r_state <= bus.lcr[3] ? ST_PARITY : ST_STOP;
                                else
                                    r_bits <= r_bits - 3'd1;
                            end
                        end
                        ST_PARITY: begin
                            if (r_cnt != 4'd0) begin
                                r_cnt <= r_cnt - 4'd1;
                            end else begin
                                r_par    <= w_rx;
                                r_pe_nxt <= (w_rx != w_exp_par);
                                r_cnt    <= 4'd15;
                                r_state  <= ST_STOP;
                            end
                        end
                        ST_STOP: begin
                            if (r_cnt != 4'd0) begin
                                r_cnt <= r_cnt - 4'd1;
                            end else begin
                                // a pop on this edge frees the slot for the new character
                                if (!r_valid || bus.rx_pop) begin
                                    r_data  <= r_shift;
                                    r_pe    <= bus.lcr[3] & r_pe_nxt;
                                    r_fe    <= ~w_rx;
                                    r_bi    <= w_bi_nxt;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_ovr <= 1'b1;
                                end
                                r_state <= w_rx ? ST_IDLE : ST_WAIT_HIGH;
                            end
                        end
                        ST_WAIT_HIGH: begin
                            if (w_rx)
                                r_state <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.rx_pe      = r_pe;
    assign bus.rx_fe      = r_fe;
    assign bus.rx_bi      = r_bi;
    assign bus.rx_overrun = r_ovr;
    assign bus.rstate     = r_state;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised and directed frames against a bit-level UART line model; a negedge monitor scores captures.
module tb_uart_rx_deframer;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic wb_rst_i;

    uart_rx_deframer_if bus_if();

    uart_rx_deframer #(.SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_cap = 0;
    int   frame_c = 0;
    logic force_pop = 1'b0;
    logic mon_pop = 1'b0;
    logic auto_pop = 1'b1;
    logic en_div = 1'b0;
    logic en_q = 1'b1;
    logic seen = 1'b0;
    logic pop_prev = 1'b0;

    assign bus_if.rx_pop = force_pop | mon_pop;
    assign bus_if.enable = en_q;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        en_q = en_div ? ~en_q : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // parity bit a correct transmitter would send for these data bits
    function automatic logic exp_par(input logic [7:0] dm, input logic [7:0] l);
        int ones;
        ones = $countones(dm);
        if (l[5]) return ~l[4];
        return l[4] ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
    endfunction

    function automatic exp_t model(input logic [7:0] dm, input logic [7:0] l, input logic p, input logic s);
        exp_t r;
        r.d  = dm;
        r.pe = l[3] && (p != exp_par(dm, l));
        r.fe = !s;
        r.bi = (dm == 8'd0) && (!l[3] || !p) && !s;
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [7:0] l, input bit par_ok,
                              input bit stop_b, input int per, input bit expect_cap,
                              input bit pop_cap, input int rst_at);
        int          n;
        int          nb;
        int          cap;
        logic [11:0] bits_v;
        logic [7:0]  dm;
        logic        p;
        n  = 5 + int'(l[1:0]);
        dm = '0;
        for (int i = 0; i < n; i++) dm[i] = d[i];
        p = exp_par(dm, l) ^ ~par_ok;
        bits_v = '0;
        for (int i = 0; i < n; i++) bits_v[1+i] = dm[i];
        nb = 1 + n;
        if (l[3]) begin
            bits_v[nb] = p;
            nb++;
        end
        bits_v[nb] = stop_b;
        nb++;
        bus_if.lcr = l;
        if (expect_cap) exp_q.push_back(model(dm, l, p, stop_b));
        frame_c = cyc;
        // first low seen by the FSM SYNC+1 edges after the pad, then 8 to mid start, 16 per bit to mid stop
        cap = frame_c + SYNC + 1 + 8 + 16 * (n + int'(l[3]) + 1);
        for (int i = 0; i < nb * per; i++) begin
            bus_if.srx_pad_i = bits_v[i / per];
            force_pop        = pop_cap && (cyc == cap - 1);
            bus_if.rx_reset  = (i == rst_at);
            tick(1);
        end
        bus_if.srx_pad_i = 1'b1;
        force_pop        = 1'b0;
        bus_if.rx_reset  = 1'b0;
        tick(16 + int'($urandom_range(0, 12)));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!wb_rst_i && bus_if.rx_valid && (!seen || pop_prev)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_unexpected: got char 0x%0h, expected none (cycle %0d)", bus_if.rx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", 32'(bus_if.rx_data), 32'(e.d));
                chk("rx_pe", 32'(bus_if.rx_pe), 32'(e.pe));
                chk("rx_fe", 32'(bus_if.rx_fe), 32'(e.fe));
                chk("rx_bi", 32'(bus_if.rx_bi), 32'(e.bi));
            end
            seen     = 1'b1;
            last_cap = cyc;
            mon_pop  = auto_pop;
        end else begin
            if (!bus_if.rx_valid) seen = 1'b0;
            mon_pop = 1'b0;
        end
        pop_prev = (force_pop | mon_pop) & bus_if.rx_valid;
    end

    initial begin
        int c;
        wb_rst_i         = 1'b1;
        bus_if.srx_pad_i = 1'b1;
        bus_if.lcr       = 8'h03;
        bus_if.lsr_mask  = 1'b0;
        bus_if.rx_reset  = 1'b0;
        tick(4);
        chk("reset_rstate", 32'(bus_if.rstate), 32'd0);
        chk("reset_valid", 32'(bus_if.rx_valid), 32'd0);
        chk("reset_data", 32'(bus_if.rx_data), 32'd0);
        chk("reset_flags", 32'({bus_if.rx_pe, bus_if.rx_fe, bus_if.rx_bi}), 32'd0);
        chk("reset_overrun", 32'(bus_if.rx_overrun), 32'd0);
        wb_rst_i = 1'b0;
        tick(5);

        send_frame(8'h55, 8'h03, 1, 1, 16, 1, 0, -1);
        chk("latency_8n1", 32'(last_cap - frame_c), 32'(SYNC + 1 + 8 + 16 * 9));
        send_frame(8'h35, 8'h1A, 0, 1, 16, 1, 0, -1);
        send_frame(8'h35, 8'h1A, 1, 1, 16, 1, 0, -1);
        send_frame(8'h0A, 8'h00, 1, 1, 16, 1, 0, -1);
        chk("drain_basic", 32'(exp_q.size()), 32'd0);

        c = cyc;
        bus_if.srx_pad_i = 1'b0;
        tick(4);
        bus_if.srx_pad_i = 1'b1;
        tick(2);
        chk("glitch_in_start", 32'(bus_if.rstate), 32'd1);
        tick(30);
        chk("glitch_idle", 32'(bus_if.rstate), 32'd0);
        chk("glitch_no_char", 32'(bus_if.rx_valid), 32'd0);

        bus_if.lcr = 8'h03;
        exp_q.push_back(model(8'h00, 8'h03, 1'b0, 1'b0));
        c = cyc;
        bus_if.srx_pad_i = 1'b0;
        tick(200);
        chk("break_wait_high", 32'(bus_if.rstate), 32'd5);
        tick(100);
        bus_if.srx_pad_i = 1'b1;
        tick(20);
        chk("break_released", 32'(bus_if.rstate), 32'd0);
        send_frame(8'hA5, 8'h03, 1, 1, 16, 1, 0, -1);
        chk("drain_break", 32'(exp_q.size()), 32'd0);

        auto_pop = 1'b0;
        send_frame(8'h11, 8'h03, 1, 1, 16, 1, 0, -1);
        send_frame(8'h22, 8'h03, 1, 1, 16, 0, 0, -1);
        chk("ovr_set", 32'(bus_if.rx_overrun), 32'd1);
        chk("ovr_hold_data", 32'(bus_if.rx_data), 32'h11);
        chk("ovr_hold_valid", 32'(bus_if.rx_valid), 32'd1);
        bus_if.lsr_mask = 1'b1;
        tick(1);
        bus_if.lsr_mask = 1'b0;
        chk("ovr_cleared", 32'(bus_if.rx_overrun), 32'd0);
        send_frame(8'h33, 8'h03, 1, 1, 16, 1, 1, -1);
        chk("popcap_valid", 32'(bus_if.rx_valid), 32'd1);
        chk("popcap_data", 32'(bus_if.rx_data), 32'h33);
        chk("popcap_no_ovr", 32'(bus_if.rx_overrun), 32'd0);
        send_frame(8'h44, 8'h03, 1, 1, 16, 0, 0, -1);
        chk("ovr_again", 32'(bus_if.rx_overrun), 32'd1);
        send_frame(8'hFF, 8'h03, 1, 1, 16, 0, 0, 50);
        chk("rxreset_valid", 32'(bus_if.rx_valid), 32'd0);
        chk("rxreset_rstate", 32'(bus_if.rstate), 32'd0);
        chk("rxreset_keeps_ovr", 32'(bus_if.rx_overrun), 32'd1);
        bus_if.lsr_mask = 1'b1;
        tick(1);
        bus_if.lsr_mask = 1'b0;
        auto_pop = 1'b1;
        tick(4);

        for (int k = 0; k < 16; k++)
            send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) != 0), 16, 1, 0, -1);
        en_div = 1'b1;
        tick(2);
        for (int k = 0; k < 8; k++)
            send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) != 0), 32, 1, 0, -1);
        en_div = 1'b0;
        tick(50);
        chk("drain_final", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
